// File: rtl/updown_sevenseg_counter_pkg.sv
// Shared seven-segment constants and elaboration helpers for the up/down counter.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD digit to segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Decimal digit 'index' of 'value'; used to build the MAX_COUNT BCD constant.
  function automatic logic [3:0] dec_digit(input int unsigned value, input int unsigned index);
    int unsigned v;
    v = value;
    for (int unsigned i = 0; i < index; i++) v = v / 10;
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/updown_sevenseg_counter_if.sv
// Control/status bundle of the up/down seven-segment counter.
//   en, inc, dec, load, load_bcd : requests toward the counter
//   bcd, hexout, at_max, at_min, wrap_pulse : counter state and display
interface updown_sevenseg_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  inc;
  logic                  dec;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   hexout;
  logic                  at_max;
  logic                  at_min;
  logic                  wrap_pulse;

  modport master (
    output en, inc, dec, load, load_bcd,
    input  bcd, hexout, at_max, at_min, wrap_pulse
  );

  modport slave (
    input  en, inc, dec, load, load_bcd,
    output bcd, hexout, at_max, at_min, wrap_pulse
  );
endinterface

// File: rtl/updown_sevenseg_counter_bcd_digit.sv
// One BCD digit of the counter chain.
//   clk, rst     : clock, async active-low reset
//   up, down     : step this digit (carry/borrow in); load/load_d : parallel load
//   digit        : registered digit value; digit_nxt_c : value after this edge
//   carry_out    : this digit rolls 9->0 while stepping up
//   borrow_out   : this digit rolls 0->9 while stepping down
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] digit,
  output logic [3:0] digit_nxt_c,
  output logic       carry_out,
  output logic       borrow_out
);

  assign carry_out  = up   && (digit == 4'd9);
  assign borrow_out = down && (digit == 4'd0);

  // Next digit value: load wins, then up, then down.
  always_comb begin
    digit_nxt_c = digit;
    if (load)      digit_nxt_c = load_d;
    else if (up)   digit_nxt_c = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    else if (down) digit_nxt_c = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit <= 4'd0;
    else      digit <= digit_nxt_c;
  end

endmodule

// File: rtl/updown_sevenseg_counter.sv
// N-digit decimal up/down counter with active-low seven-segment outputs.
//   clk : system clock      rst : async active-low reset
//   bus : updown_sevenseg_counter_if.slave (en/inc/dec/load/load_bcd in,
//         bcd/hexout/at_max/at_min/wrap_pulse out)
// Optional: define SEVSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module updown_sevenseg_counter
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_COUNT   = 9999,
  parameter int unsigned WRAP        = 1,
  parameter int unsigned EDGE_DETECT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  updown_sevenseg_counter_if.slave bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;

  // Display reset pattern: all zeros, or a lone "0" when blanking is enabled.
  function automatic logic [HW-1:0] hex_reset();
    logic [HW-1:0] r;
    for (int i = 0; i < int'(DIGITS); i++) begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      r[7*i +: 7] = (i == 0) ? SEG_0 : SEG_BLANK;
`else
      r[7*i +: 7] = SEG_0;
`endif
    end
    return r;
  endfunction

  localparam logic [HW-1:0] HEX_RST = hex_reset();

  logic            inc_q, dec_q, inc_ev, dec_ev;
  logic [BW-1:0]   max_bcd, bcd_q, bcd_nxt, load_clamp, load_val;
  logic [DIGITS:0] carry, borrow;
  logic            do_inc, do_dec, do_load, wrap_c, is_max, is_min;
  logic            at_max_q, at_min_q, wrap_q;
  logic [HW-1:0]   hex_c, hex_q;
  logic [DIGITS-1:0] blank;
  logic            unused_chain_c;

  // Request edge history, updated regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= bus.inc;
      dec_q <= bus.dec;
    end
  end

  assign inc_ev = (EDGE_DETECT != 0) ? (bus.inc & ~inc_q) : bus.inc;
  assign dec_ev = (EDGE_DETECT != 0) ? (bus.dec & ~dec_q) : bus.dec;

  assign is_max = (bcd_q == max_bcd);
  assign is_min = (bcd_q == '0);

  // Load value check: any non-decimal digit or value above MAX_COUNT clamps to MAX_COUNT.
  always_comb begin
    logic inv, gt, decided;
    inv     = 1'b0;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (bus.load_bcd[4*i +: 4] > 4'd9) inv = 1'b1;
      if (!decided) begin
        if (bus.load_bcd[4*i +: 4] > max_bcd[4*i +: 4]) begin
          gt      = 1'b1;
          decided = 1'b1;
        end else if (bus.load_bcd[4*i +: 4] < max_bcd[4*i +: 4]) begin
          decided = 1'b1;
        end
      end
    end
    load_clamp = (inv || gt) ? max_bcd : bus.load_bcd;
  end

  // Request priority and bound handling; wrapping is done as a parallel load.
  always_comb begin
    do_inc   = 1'b0;
    do_dec   = 1'b0;
    do_load  = 1'b0;
    wrap_c   = 1'b0;
    load_val = load_clamp;
    if (bus.en) begin
      if (bus.load) begin
        do_load = 1'b1;
      end else if (inc_ev && !dec_ev) begin
        if (!is_max) begin
          do_inc = 1'b1;
        end else if (WRAP != 0) begin
          do_load  = 1'b1;
          load_val = '0;
          wrap_c   = 1'b1;
        end
      end else if (dec_ev && !inc_ev) begin
        if (!is_min) begin
          do_dec = 1'b1;
        end else if (WRAP != 0) begin
          do_load  = 1'b1;
          load_val = max_bcd;
          wrap_c   = 1'b1;
        end
      end
    end
  end

  assign carry[0]  = do_inc;
  assign borrow[0] = do_dec;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    localparam logic [3:0] MAX_D = dec_digit(MAX_COUNT, i);
    assign max_bcd[4*i +: 4] = MAX_D;

    bcd_digit u_digit (
      .clk         (clk),
      .rst         (rst),
      .up          (carry[i]),
      .down        (borrow[i]),
      .load        (do_load),
      .load_d      (load_val[4*i +: 4]),
      .digit       (bcd_q[4*i +: 4]),
      .digit_nxt_c (bcd_nxt[4*i +: 4]),
      .carry_out   (carry[i+1]),
      .borrow_out  (borrow[i+1])
    );
  end

  // The top digit never carries or borrows out because of the bound check.
  assign unused_chain_c = carry[DIGITS] ^ borrow[DIGITS];

  // Flags track the count being written on this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      at_max_q <= (bcd_nxt == max_bcd);
      at_min_q <= (bcd_nxt == '0);
      wrap_q   <= wrap_c;
    end
  end

  // Segment decode of the current count, with optional leading-zero blanking.
  always_comb begin
    blank = '0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (lead && (bcd_q[4*i +: 4] == 4'd0)) blank[i] = 1'b1;
        else                                   lead     = 1'b0;
      end
    end
`endif
    for (int i = 0; i < int'(DIGITS); i++) begin
      hex_c[7*i +: 7] = blank[i] ? SEG_BLANK : bcd_to_seg(bcd_q[4*i +: 4]);
    end
  end

  // Display register: one cycle behind bcd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hex_q <= HEX_RST;
    else      hex_q <= hex_c;
  end

  assign bus.bcd        = bcd_q;
  assign bus.hexout     = hex_q;
  assign bus.at_max     = at_max_q;
  assign bus.at_min     = at_min_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_updown_sevenseg_counter.sv
// Bench: three counter configurations share one stimulus stream and are
// checked every cycle against an integer-count model, plus literal checks.
module tb_updown_sevenseg_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0;
  logic [15:0] load_bcd = 16'h0;
  bit          running = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // a: 2 digits, max 59, wrap, edge   b: same but saturate   c: 4 digits, max 1234, wrap, level
  localparam int DIG  [3] = '{2, 2, 4};
  localparam int MAXC [3] = '{59, 59, 1234};
  localparam int WRP  [3] = '{1, 0, 1};
  localparam int EDG  [3] = '{1, 1, 0};

  updown_sevenseg_counter_if #(.DIGITS(2)) if_a ();
  updown_sevenseg_counter_if #(.DIGITS(2)) if_b ();
  updown_sevenseg_counter_if #(.DIGITS(4)) if_c ();

  assign if_a.en = en;  assign if_a.inc = inc;  assign if_a.dec = dec;
  assign if_a.load = load;  assign if_a.load_bcd = load_bcd[7:0];
  assign if_b.en = en;  assign if_b.inc = inc;  assign if_b.dec = dec;
  assign if_b.load = load;  assign if_b.load_bcd = load_bcd[7:0];
  assign if_c.en = en;  assign if_c.inc = inc;  assign if_c.dec = dec;
  assign if_c.load = load;  assign if_c.load_bcd = load_bcd;

  updown_sevenseg_counter #(.DIGITS(2), .MAX_COUNT(59), .WRAP(1), .EDGE_DETECT(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  updown_sevenseg_counter #(.DIGITS(2), .MAX_COUNT(59), .WRAP(0), .EDGE_DETECT(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  updown_sevenseg_counter #(.DIGITS(4), .MAX_COUNT(1234), .WRAP(1), .EDGE_DETECT(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [15:0] a_bcd [3];
  logic [27:0] a_hex [3];
  logic        a_max [3], a_min [3], a_wrap [3];
  assign a_bcd[0] = 16'(if_a.bcd);  assign a_hex[0] = 28'(if_a.hexout);
  assign a_bcd[1] = 16'(if_b.bcd);  assign a_hex[1] = 28'(if_b.hexout);
  assign a_bcd[2] = if_c.bcd;       assign a_hex[2] = if_c.hexout;
  assign a_max[0] = if_a.at_max; assign a_min[0] = if_a.at_min; assign a_wrap[0] = if_a.wrap_pulse;
  assign a_max[1] = if_b.at_max; assign a_min[1] = if_b.at_min; assign a_wrap[1] = if_b.wrap_pulse;
  assign a_max[2] = if_c.at_max; assign a_min[2] = if_c.at_min; assign a_wrap[2] = if_c.wrap_pulse;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  `ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UPPER_ZERO = 7'b1111111;
  `else
  localparam logic [6:0] UPPER_ZERO = 7'b1000000;
  `endif

  // Expected display for an integer count on configuration k.
  function automatic logic [27:0] disp(input int k, input int c);
    logic [27:0] r;
    logic [6:0]  s;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIG[k]; i++) begin
      s = seg_tab[(c / p) % 10];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      if (i > 0 && c < p) s = 7'b1111111;
`endif
      r[7*i +: 7] = s;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r;
    int          v;
    v = c;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer count per configuration.
  int          cnt  [3];
  bit          iq   [3], dq [3], wr [3];
  logic [27:0] mhex [3];

  always @(posedge clk or negedge rst) begin : model
    bit ie, de, inv;
    int lv, p, d;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        cnt[k] = 0; iq[k] = 0; dq[k] = 0; wr[k] = 0;
        mhex[k] = disp(k, 0);
      end else begin
        mhex[k] = disp(k, cnt[k]);
        wr[k] = 0;
        ie = (EDG[k] != 0) ? (inc && !iq[k]) : inc;
        de = (EDG[k] != 0) ? (dec && !dq[k]) : dec;
        if (en) begin
          if (load) begin
            lv = 0; p = 1; inv = 0;
            for (int i = 0; i < DIG[k]; i++) begin
              d = int'((load_bcd >> (4 * i)) & 16'hF);
              if (d > 9) inv = 1;
              lv = lv + d * p;
              p = p * 10;
            end
            cnt[k] = (inv || lv > MAXC[k]) ? MAXC[k] : lv;
          end else if (ie && !de) begin
            if (cnt[k] < MAXC[k]) cnt[k] = cnt[k] + 1;
            else if (WRP[k] != 0) begin cnt[k] = 0; wr[k] = 1; end
          end else if (de && !ie) begin
            if (cnt[k] > 0) cnt[k] = cnt[k] - 1;
            else if (WRP[k] != 0) begin cnt[k] = MAXC[k]; wr[k] = 1; end
          end
        end
        iq[k] = inc;
        dq[k] = dec;
      end
    end
  end

  // Every-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    if (running) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("bcd[%0d]", k),  32'(a_bcd[k]),  32'(to_bcd(cnt[k])));
        chk($sformatf("hex[%0d]", k),  32'(a_hex[k]),  32'(mhex[k]));
        chk($sformatf("max[%0d]", k),  32'(a_max[k]),  32'(cnt[k] == MAXC[k]));
        chk($sformatf("min[%0d]", k),  32'(a_min[k]),  32'(cnt[k] == 0));
        chk($sformatf("wrap[%0d]", k), 32'(a_wrap[k]), 32'(wr[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_inc();
    inc = 1'b1; step(); inc = 1'b0; step();
  endtask

  initial begin
    // Reset and idle.
    step(); step();
    chk("rst_bcd",  32'(if_a.bcd), 32'h0);
    chk("rst_hex",  32'(if_a.hexout), 32'({UPPER_ZERO, 7'b1000000}));
    chk("rst_min",  32'(if_a.at_min), 32'h1);
    chk("rst_max",  32'(if_a.at_max), 32'h0);
    chk("rst_wrap", 32'(if_a.wrap_pulse), 32'h0);
    rst = 1'b1; en = 1'b1; running = 1'b1;
    repeat (4) step();
    chk("idle_bcd", 32'(if_a.bcd), 32'h0);
    chk("idle_hex", 32'(if_a.hexout), 32'({UPPER_ZERO, 7'b1000000}));

    // Edge counting, saturation and wrap at the top.
    inc = 1'b1; repeat (5) step(); inc = 1'b0;
    chk("edge_once", 32'(if_a.bcd), 32'h01);
    chk("level_five", 32'(if_c.bcd), 32'h0005);
    step();
    repeat (58) pulse_inc();
    chk("reach_max", 32'(if_a.bcd), 32'h59);
    chk("at_max", 32'(if_a.at_max), 32'h1);
    inc = 1'b1; step(); inc = 1'b0;
    chk("wrap_top", 32'(if_a.bcd), 32'h00);
    chk("wrap_pulse", 32'(if_a.wrap_pulse), 32'h1);
    chk("sat_top", 32'(if_b.bcd), 32'h59);
    chk("sat_nopulse", 32'(if_b.wrap_pulse), 32'h0);
    step();
    chk("wrap_one_cycle", 32'(if_a.wrap_pulse), 32'h0);

    // Carry 09->10, borrow 10->09.
    load = 1'b1; load_bcd = 16'h0009; step(); load = 1'b0;
    chk("load_09", 32'(if_a.bcd), 32'h09);
    step();
    chk("hex_d1_zero", 32'(if_a.hexout[13:7]), 32'(UPPER_ZERO));
    inc = 1'b1; step(); inc = 1'b0;
    chk("carry", 32'(if_a.bcd), 32'h10);
    step();
    chk("hex_d1_one", 32'(if_a.hexout[13:7]), 32'(7'b1111001));
    dec = 1'b1; step(); dec = 1'b0;
    chk("borrow", 32'(if_a.bcd), 32'h09);

    // Bottom bound: wrap versus saturate.
    load = 1'b1; load_bcd = 16'h0000; step(); load = 1'b0;
    dec = 1'b1; step(); dec = 1'b0;
    chk("sat_bottom", 32'(if_b.bcd), 32'h00);
    chk("sat_bot_nopulse", 32'(if_b.wrap_pulse), 32'h0);
    chk("wrap_bottom", 32'(if_a.bcd), 32'h59);
    chk("wrap_bot_pulse", 32'(if_a.wrap_pulse), 32'h1);

    // Priority cases.
    load = 1'b1; load_bcd = 16'h0007; step(); load = 1'b0;
    inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
    chk("inc_dec_hold", 32'(if_a.bcd), 32'h07);
    step();
    load = 1'b1; load_bcd = 16'h0042; inc = 1'b1; step(); load = 1'b0; inc = 1'b0;
    chk("load_over_inc", 32'(if_a.bcd), 32'h42);
    step();
    load = 1'b1; load_bcd = 16'h007A; step(); load = 1'b0;
    chk("clamp_2d", 32'(if_a.bcd), 32'h59);
    chk("clamp_4d", 32'(if_c.bcd), 32'h1234);
    en = 1'b0; inc = 1'b1; step(); en = 1'b1; inc = 1'b0;
    chk("en_low", 32'(if_a.bcd), 32'h59);
    step();

    // Level mode latency.
    rst = 1'b0; step(); rst = 1'b1;
    inc = 1'b1;
    step();
    chk("lvl_bcd1", 32'(if_c.bcd), 32'h0001);
    chk("lvl_hex1", 32'(if_c.hexout[6:0]), 32'(7'b1000000));
    step();
    chk("lvl_bcd2", 32'(if_c.bcd), 32'h0002);
    chk("lvl_hex2", 32'(if_c.hexout[6:0]), 32'(7'b1111001));
    step();
    chk("lvl_bcd3", 32'(if_c.bcd), 32'h0003);
    chk("lvl_hex3", 32'(if_c.hexout[6:0]), 32'(7'b0100100));
    inc = 1'b0;
    step();

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    load = 1'b1; load_bcd = 16'h0005; step(); load = 1'b0; step();
    chk("blank_5", 32'(if_c.hexout), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}));
`endif

    // Asynchronous reset mid-cycle.
    load = 1'b1; load_bcd = 16'h0042; step(); load = 1'b0;
    chk("pre_rst_a", 32'(if_a.bcd), 32'h42);
    chk("pre_rst_c", 32'(if_c.bcd), 32'h0042);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_a", 32'(if_a.bcd), 32'h0);
    chk("async_rst_c", 32'(if_c.bcd), 32'h0);
    chk("async_rst_min", 32'(if_a.at_min), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    repeat (3000) begin
      en   = ($urandom_range(0, 9) != 0);
      inc  = ($urandom_range(0, 2) == 0);
      dec  = ($urandom_range(0, 2) == 0);
      load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 4; i++) load_bcd[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 0) load_bcd[15:8] = 8'h00;
      end else begin
        load_bcd = 16'($urandom);
      end
      step();
    end

    inc = 1'b0; dec = 1'b0; load = 1'b0;
    step();
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_sevenseg_counter.md
Name: updown_sevenseg_counter

Overview:
Parametrised N-digit decimal up/down counter driving active-low seven-segment displays. It is the multi-digit successor to the single-digit 2-bit inc/dec display FSM. It adds configurable digit count and modulus, wrap or saturate mode, edge-qualified inc/dec, synchronous load, and boundary flags. It sits between debounced board pushbuttons and the hex display pins.

Parameters:
- DIGITS, 4: number of BCD digits; range 1..8.
- MAX_COUNT, 9999: largest count value, in decimal; must satisfy 0 < MAX_COUNT < 10^DIGITS.
- WRAP, 1: 1 means wrap around (MAX→0 and 0→MAX); 0 means saturate at the bounds.
- EDGE_DETECT, 1: 1 means act on the rising edge of inc/dec only; 0 means act on every cycle the input is high (level mode).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, inc, dec and load are ignored and edge history still updates.
- inc  in  1  increment request.
- dec  in  1  decrement request.
- load  in  1  synchronous load strobe.
- load_bcd  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- bcd  out  4*DIGITS  current count, in BCD.
- hexout  out  7*DIGITS  segments per digit, {g,f,e,d,c,b,a}, active-low; digit 0 is in bits [6:0].
- at_max  out  1  high when count == MAX_COUNT.
- at_min  out  1  high when count == 0.
- wrap_pulse  out  1  one-cycle pulse on a wrap event.

Behaviour:
- Reset (rst low, asynchronous):
  - bcd = 0 and the inc/dec edge registers = 0.
  - Every digit of hexout = 7'b1000000.
  - at_min = 1, at_max = 0, wrap_pulse = 0.
- Request qualification:
  - EDGE_DETECT=1: inc_ev = inc & ~inc_q, where inc_q is inc registered each cycle. dec_ev is formed the same way.
  - EDGE_DETECT=0: inc_ev = inc and dec_ev = dec.
- Priority, evaluated only when en=1:
  1. load is highest priority.
  2. inc_ev & dec_ev together → hold.
  3. inc_ev alone → increment.
  4. dec_ev alone → decrement.
  5. Otherwise hold.
- Load:
  - Any digit > 9, or a value > MAX_COUNT → bcd = MAX_COUNT.
  - Otherwise bcd = load_bcd.
  - A load never asserts wrap_pulse.
- Increment:
  - Digit-serial BCD carry: a digit at 9 becomes 0 and carries to the next digit.
  - At MAX_COUNT with WRAP=1 → 0 and wrap_pulse=1.
  - At MAX_COUNT with WRAP=0 → hold, no pulse.
- Decrement:
  - BCD borrow: a digit at 0 becomes 9 and borrows from the next digit.
  - At 0 with WRAP=1 → MAX_COUNT and wrap_pulse=1.
  - At 0 with WRAP=0 → hold.
- Latency:
  - bcd, at_max, at_min and wrap_pulse update on the same clock edge that samples the qualifying event.
  - hexout is registered from the new bcd and lags bcd by exactly one cycle.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Level mode with inc held: count advances one step per cycle.
- Reset mid-count: all state returns to reset values immediately, with no waiting for clk.

Optional Feature:
- Macro: SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Every zero digit above the most-significant nonzero digit displays 7'b1111111 (blank).
  - Digit 0 is always displayed, so a count of 0 shows a single "0".
  - Blanking follows the same one-cycle registered path as hexout.
- Undefined: all digits are displayed, including leading zeros. Reset hexout is all-digits "0" in both builds, except that blanking applies to the upper digits when the macro is defined.

Decomposition:
- Package sevenseg_pkg contains:
  - SEG_0..SEG_9 and SEG_BLANK 7-bit constants.
  - Function bcd_to_seg(4-bit) → 7-bit; invalid inputs map to SEG_BLANK.
  - Function dec_digit(value, index), which derives the per-digit MAX_COUNT BCD constant at elaboration.
- Sub-module bcd_digit:
  - Inputs: up, down, load and load_d.
  - Outputs: digit, plus carry_out and borrow_out toward the next digit.
  - Instantiated DIGITS times in a generate loop.
- The top level holds edge detection, bound compare, wrap/saturate control and the display register.

Test Plan:
1. Reset, then idle. Hold rst low 2 cycles, release, keep inc=dec=0 for 4 cycles → bcd=0, hexout=all 7'b1000000, at_min=1, count unchanged.
2. Edge counting, wrap, carry and borrow (DIGITS=2, MAX_COUNT=59, WRAP=1, EDGE_DETECT=1).
   - Hold inc high 5 cycles → count advances once to 1.
   - Pulse inc 58 more times → 59, at_max=1.
   - One more pulse → 0 with a 1-cycle wrap_pulse.
   - Check carry 09→10 and borrow 10→09, with hexout of digit 1 going from 1000000 to 1111001.
3. Saturation (WRAP=0). At 0, pulse dec → stays 0, no wrap_pulse. At 59, pulse inc → stays 59.
4. Simultaneous and priority cases.
   - inc & dec rising together at count 7 → stays 7.
   - load=1 with load_bcd=8'h42 and inc pulse together → 42.
   - load_bcd=8'h7A → clamps to 59.
   - en=0 with an inc pulse → no change.
5. Latency and level mode (EDGE_DETECT=0).
   - Hold inc 3 cycles from 0 → bcd 1,2,3 on consecutive edges.
   - hexout follows one cycle later each time.
6. Async reset and blanking.
   - Assert rst mid-cycle at count 42 → bcd=0 before the next clk edge.
   - With SEVSEG_LEADING_ZERO_BLANK_EN defined, count 5 on 4 digits → upper three digits 7'b1111111, digit 0 shows 7'b0010010.
